// File: rtl/traffic_pkg.sv
// Shared types and constants for the traffic controller: FSM state encoding,
// countdown widths and the per-approach lamp bit positions.
package traffic_pkg;

  typedef enum logic [2:0] {
    ST_GREEN,
    ST_FLASH,
    ST_YELLOW,
    ST_ALL_RED,
    ST_NIGHT
  } state_t;

  localparam int BCD_W   = 4;
  localparam int SEC_W   = 7;
  localparam int MAX_SEC = 99;

  localparam int LAMP_R = 0;
  localparam int LAMP_Y = 1;
  localparam int LAMP_G = 2;

endpackage

// File: rtl/tick_gen.sv
// One-second tick prescaler with a 50% blink phase derived from the same count.
module tick_gen #(
  parameter int TICK_DIV = 50000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick,
  output logic blink
);

  localparam int PW = $clog2(TICK_DIV);

  logic [PW-1:0] presc;

  assign tick  = (presc == PW'(TICK_DIV - 1));
  assign blink = (presc < PW'(TICK_DIV / 2));

  // NOTE: registers use <= so every flop samples pre-edge values; blocking here would race other always_ff blocks.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

endmodule

// File: rtl/traffic_ctrl_n.sv
// Round-robin traffic light controller with BCD countdown and night blink.
// Define TRAFFIC_PED_EN to add pedestrian requests that shorten cross-traffic green.
module traffic_ctrl_n
  import traffic_pkg::*;
#(
  parameter int NUM_DIR   = 2,
  parameter int TICK_DIV  = 50000000,
  parameter int GREEN_S   = 20,
  parameter int FLASH_S   = 5,
  parameter int YELLOW_S  = 4,
  parameter int ALL_RED_S = 1,
  parameter int PED_CUT_S = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               day_night,
  input  logic [NUM_DIR-1:0] ped_req,
  output logic [NUM_DIR-1:0] light_r,
  output logic [NUM_DIR-1:0] light_y,
  output logic [NUM_DIR-1:0] light_g,
  output logic [1:0]         active_dir,
  output logic [BCD_W-1:0]   cnt_tens,
  output logic [BCD_W-1:0]   cnt_ones,
  output logic               cnt_valid,
  output logic [NUM_DIR-1:0] ped_ack
);

  state_t           state;
  logic [1:0]       active_dir_q;
  logic [1:0]       next_dir;
  logic [SEC_W-1:0] sec_cnt;
  logic             tick, blink, presc_clr;
  logic             ped_cut;
  logic             enter_green;
  logic [2:0]       lamp;
  logic [BCD_W-1:0] tens, ones;

  // Prescaler restarts whenever the controller enters or leaves night mode.
  assign presc_clr = (state == ST_NIGHT) == day_night;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk   (clk),
    .rst   (rst),
    .clr   (presc_clr),
    .tick  (tick),
    .blink (blink)
  );

  assign next_dir    = (active_dir_q == 2'(NUM_DIR - 1)) ? 2'd0 : active_dir_q + 2'd1;
  assign enter_green = day_night && (state == ST_ALL_RED) && tick && (sec_cnt == SEC_W'(1));
  assign active_dir  = active_dir_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_GREEN;
      active_dir_q <= 2'd0;
      sec_cnt      <= SEC_W'(GREEN_S);
    end else if (!day_night) begin
      state   <= ST_NIGHT;
      sec_cnt <= '0;
    end else if (state == ST_NIGHT) begin
      // Re-enter as if the last approach just finished so approach 0 goes next.
      state        <= ST_ALL_RED;
      active_dir_q <= 2'(NUM_DIR - 1);
      sec_cnt      <= SEC_W'(ALL_RED_S);
    end else if (ped_cut) begin
      sec_cnt <= SEC_W'(PED_CUT_S);
    end else if (tick && sec_cnt == SEC_W'(1)) begin
      case (state)
        ST_GREEN: begin
          state   <= ST_FLASH;
          sec_cnt <= SEC_W'(FLASH_S);
        end
        ST_FLASH: begin
          state   <= ST_YELLOW;
          sec_cnt <= SEC_W'(YELLOW_S);
        end
        ST_YELLOW: begin
          state   <= ST_ALL_RED;
          sec_cnt <= SEC_W'(ALL_RED_S);
        end
        default: begin
          state        <= ST_GREEN;
          active_dir_q <= next_dir;
          sec_cnt      <= SEC_W'(GREEN_S);
        end
      endcase
    end else if (tick) begin
      sec_cnt <= sec_cnt - 1'b1;
    end
  end

`ifdef TRAFFIC_PED_EN
  logic [NUM_DIR-1:0] pending, ped_ack_q, dir_mask, next_mask;

  assign dir_mask  = NUM_DIR'(1) << active_dir_q;
  assign next_mask = NUM_DIR'(1) << next_dir;
  assign ped_cut   = (state == ST_GREEN) && (|(pending & ~dir_mask)) &&
                     (sec_cnt > SEC_W'(PED_CUT_S));
  assign ped_ack   = ped_ack_q;

  always_ff @(posedge clk) begin
    if (rst || !day_night || state == ST_NIGHT) begin
      pending   <= '0;
      ped_ack_q <= '0;
    end else if (enter_green) begin
      // A request landing on the serving edge is absorbed by this green.
      pending   <= (pending | ped_req) & ~next_mask;
      ped_ack_q <= (pending | ped_req) & next_mask;
    end else begin
      pending   <= pending | ped_req;
      ped_ack_q <= '0;
    end
  end
`else
  logic unused_ped;
  logic unused_enter;

  assign unused_ped   = ^ped_req;
  assign unused_enter = enter_green;
  assign ped_cut      = 1'b0;
  assign ped_ack      = '0;
`endif

  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned and infers a latch.
    light_r = '0;
    light_y = '0;
    light_g = '0;
    lamp    = '0;
    if (state == ST_NIGHT) begin
      light_y = {NUM_DIR{blink}};
    end else begin
      for (int i = 0; i < NUM_DIR; i++) begin
        lamp = '0;
        if (2'(i) == active_dir_q && state != ST_ALL_RED) begin
          case (state)
            ST_GREEN:  lamp[LAMP_G] = 1'b1;
            ST_FLASH:  lamp[LAMP_G] = blink;
            ST_YELLOW: lamp[LAMP_Y] = 1'b1;
            default:   lamp[LAMP_R] = 1'b1;
          endcase
        end else begin
          lamp[LAMP_R] = 1'b1;
        end
        light_r[i] = lamp[LAMP_R];
        light_y[i] = lamp[LAMP_Y];
        light_g[i] = lamp[LAMP_G];
      end
    end
  end

  always_comb begin
    tens = '0;
    ones = sec_cnt[BCD_W-1:0];
    for (int t = 1; t <= MAX_SEC / 10; t++) begin
      if (sec_cnt >= SEC_W'(t * 10)) begin
        tens = BCD_W'(t);
        ones = BCD_W'(sec_cnt - SEC_W'(t * 10));
      end
    end
  end

  assign cnt_valid = (state != ST_NIGHT);
  assign cnt_tens  = cnt_valid ? tens : '0;
  assign cnt_ones  = cnt_valid ? ones : '0;

endmodule

// File: doc/traffic_ctrl_n.md
TRAFFIC_CTRL_N -- requirements
Module: traffic_ctrl_n

Interface
REQ-001 The block SHALL have the following parameters (name, default, meaning):
- NUM_DIR, 2: approaches served round-robin, legal range 2..4.
- TICK_DIV, 50000000: clk cycles per 1 s tick, even, >=2.
- GREEN_S, 20: solid-green seconds.
- FLASH_S, 5: flashing-green seconds.
- YELLOW_S, 4: yellow seconds.
- ALL_RED_S, 1: all-red clearance seconds.
- PED_CUT_S, 5: green remainder after pedestrian truncation.
REQ-002 Every duration parameter SHALL lie in 1..99; PED_CUT_S <= GREEN_S.
REQ-003 The block SHALL have the following ports (name, direction, width, meaning):
- clk, in, 1: single clock.
- rst, in, 1: synchronous, active-high reset.
- day_night, in, 1: 1 = day cycle, 0 = night blink.
- ped_req, in, NUM_DIR: per-approach crossing request, level or pulse.
- light_r, out, NUM_DIR: red lamps.
- light_y, out, NUM_DIR: yellow lamps.
- light_g, out, NUM_DIR: green lamps.
- active_dir, out, 2: approach currently owning green, flash or yellow.
- cnt_tens, out, 4: BCD tens of the seconds remaining in the current state.
- cnt_ones, out, 4: BCD ones of the seconds remaining in the current state.
- cnt_valid, out, 1: countdown digits meaningful.
- ped_ack, out, NUM_DIR: one-cycle pulse when a pending request is served.

Function
REQ-004 Prescaler SHALL count 0..TICK_DIV-1 and wrap; tick SHALL be high on the cycle it equals TICK_DIV-1.
REQ-005 blink SHALL be 1 while prescaler < TICK_DIV/2, else 0.
REQ-006 The FSM SHALL have the states GREEN, FLASH, YELLOW, ALL_RED and NIGHT.
REQ-007 Day transitions SHALL be: GREEN->FLASH->YELLOW->ALL_RED->GREEN.
REQ-008 On ALL_RED->GREEN, active_dir SHALL increment, wrapping NUM_DIR-1 to 0.
REQ-009 On state entry, sec_cnt (7 bit) SHALL load the state's duration.
REQ-010 Each tick SHALL decrement sec_cnt; a tick while sec_cnt==1 SHALL transition and load the next duration instead.
REQ-011 Each day state SHALL therefore last exactly duration*TICK_DIV cycles.
REQ-012 Lamps for active_dir SHALL be: GREEN g=1; FLASH g=blink; YELLOW y=1.
REQ-013 All other approaches, and every approach in ALL_RED, SHALL have r=1; exactly one lamp per approach SHALL be lit, except g=0 in FLASH.
REQ-014 cnt_tens/cnt_ones SHALL be the BCD of sec_cnt; cnt_valid=1 in every day state.
REQ-015 day_night=0 SHALL enter NIGHT on the next edge from any state.
REQ-016 In NIGHT: light_y = all blink, r=g=0, cnt_valid=0, digits 0.
REQ-017 day_night=1 in NIGHT SHALL enter ALL_RED with active_dir=NUM_DIR-1, so that the next green is approach 0.
REQ-018 The prescaler SHALL clear on entry to and exit from NIGHT.
REQ-019 Pedestrian (macro only): a ped_req[i] bit SHALL set sticky pending[i].
REQ-020 In GREEN, if any pending[j] is set for j!=active_dir and sec_cnt > PED_CUT_S, sec_cnt SHALL load PED_CUT_S; this load SHALL override a same-cycle tick decrement.
REQ-021 On entering GREEN for approach j with pending[j] set, pending[j] SHALL clear and ped_ack[j] SHALL pulse for one cycle.
REQ-022 If ped_req[j] arrives in that same cycle, the clear SHALL win and the ack covers it.
REQ-023 In NIGHT, pending SHALL be held at 0 and ped_req ignored.

Reset
REQ-024 rst SHALL force state=GREEN, active_dir=0, sec_cnt=GREEN_S, prescaler=0, pending=0, and ped_ack=0.
REQ-025 On the cycle after rst: light_g=...001, light_r=all others, cnt=BCD(GREEN_S), cnt_valid=1.
REQ-026 rst mid-phase SHALL abandon the phase with no glitch cycle.

Configuration
REQ-027 With TRAFFIC_PED_EN defined, REQ-019..REQ-023 logic SHALL be present.
REQ-028 Without TRAFFIC_PED_EN, ped_req SHALL be unused, ped_ack tied to 0, and no pending registers synthesised.

Structure
REQ-029 traffic_pkg SHALL hold the state enum, the BCD digit width, MAX_SEC=99, and the lamp index constants.
REQ-030 Prescaler and blink generation SHALL live in the sub-module tick_gen.
REQ-031 Binary-to-BCD conversion SHALL be combinational inside traffic_ctrl_n.

Verification (TICK_DIV=4, GREEN_S=3, FLASH_S=2, YELLOW_S=2, ALL_RED_S=1, PED_CUT_S=1, NUM_DIR=2)
REQ-032 Reset then day=1 -> dir0 green for cycles 0-11, flash 12-19, yellow 20-27, all-red 28-31; dir1 green at cycle 32; digits 3,2,1,2,1,2,1,1.
REQ-033 Flash phase -> light_g[0] follows 1,1,0,0 per tick period.
REQ-034 ped_req[1] pulse at cycle 2 -> sec_cnt 3->1, green ends at cycle 7, and ped_ack[1] pulses on dir1 GREEN entry.
REQ-035 day_night=0 mid-yellow -> next cycle all yellow blink, cnt_valid=0; day_night=1 -> ALL_RED for 4 cycles, then dir0 green.
REQ-036 rst asserted during dir1 flash -> next cycle dir0 green, cnt=03, pending cleared.
REQ-037 Build without TRAFFIC_PED_EN plus ped_req stimulus -> timing identical to REQ-032, ped_ack always 0.
